// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous-read memory port.
// Port 0 (core) can lock out port 1 (loader) for atomic sequences.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  lock0,
    output logic                  gnt0,
    output logic                  done0,
    output logic                  err0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    last_winner_r;
    logic                    sel_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   rdata0_r;
    logic [DATA_WIDTH-1:0]   rdata1_r;
    logic                    win0_s;
    logic                    win1_s;
    logic                    w_we_s;
    logic [ADDR_WIDTH-1:0]   w_addr_s;
    logic [DATA_WIDTH-1:0]   w_wdata_s;
    logic                    rd_ok_s;

    function automatic logic misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // Round-robin arbitration; lock0 forces the core to win and shuts out the loader.
    always_comb begin
        win0_s = 1'b0;
        win1_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_RESP)) begin
            win0_s = req0 & (~req1 | lock0 | last_winner_r);
            win1_s = req1 & ~lock0 & (~req0 | ~last_winner_r);
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
    end

    // Fields of the winning request.
    always_comb begin
        w_we_s    = we0;
        w_addr_s  = addr0;
        w_wdata_s = wdata0;
        if (win1_s) begin
            w_we_s    = we1;
            w_addr_s  = addr1;
            w_wdata_s = wdata1;
        end else begin
            w_we_s    = we0;
            w_addr_s  = addr0;
            w_wdata_s = wdata0;
        end
    end

    // The memory answers during RESP, so read data is bypassed straight through with done.
    always_comb begin
        rd_ok_s = ~we_r & ~misaligned(addr_r[1:0]);
        rdata0  = rdata0_r;
        rdata1  = rdata1_r;
        if (done0 && rd_ok_s) begin
            rdata0 = mem_q;
        end else begin
            rdata0 = rdata0_r;
        end
        if (done1 && rd_ok_s) begin
            rdata1 = mem_q;
        end else begin
            rdata1 = rdata1_r;
        end
    end

    // Transfer FSM with registered grant/done/memory outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            last_winner_r <= 1'b1;
            sel_r         <= 1'b0;
            we_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            rdata0_r      <= '0;
            rdata1_r      <= '0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_sel       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    if ((state_r == ST_RESP) && rd_ok_s) begin
                        if (sel_r) begin
                            rdata1_r <= mem_q;
                        end else begin
                            rdata0_r <= mem_q;
                        end
                    end
                    gnt0 <= win0_s;
                    gnt1 <= win1_s;
                    if (win0_s || win1_s) begin
                        sel_r         <= win1_s;
                        we_r          <= w_we_s;
                        addr_r        <= w_addr_s;
                        wdata_r       <= w_wdata_s;
                        last_winner_r <= win1_s;
                        mem_addr      <= w_addr_s;
                        mem_wdata     <= w_wdata_s;
                        mem_sel       <= (w_addr_s >= RAM_BASE);
                        mem_we        <= w_we_s & ~misaligned(w_addr_s[1:0]);
                        busy          <= 1'b1;
                        state_r       <= ST_ACCESS;
                    end else begin
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    mem_we  <= 1'b0;
                    done0   <= ~sel_r;
                    done1   <= sel_r;
                    err0    <= ~sel_r & misaligned(addr_r[1:0]);
                    err1    <= sel_r & misaligned(addr_r[1:0]);
                    busy    <= 1'b1;
                    state_r <= ST_RESP;
                end
                default: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic        mem_we, mem_sel, busy;
    logic [31:0] mem_q = 32'h0;

    int n_checks = 0;
    int n_pass = 0;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_BASE(RAM_BASE)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return ~a;
    endfunction

    // Synchronous-read memory: data appears one cycle after the address.
    always @(posedge clk) mem_q <= mem_fn(mem_addr);

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    typedef struct {
        logic gnt0, gnt1, done0, done1, err0, err1, we, busy, sel, rv0, rv1;
        logic [31:0] addr, wdata, rval;
    } exp_t;

    exp_t slot [64];
    int   cyc = 0;
    int   next_arb = 0;
    int   last_w = 1;
    int   p_s;

    function automatic exp_t blank();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Expected outputs of one cycle of a transfer (ACCESS when resp=0, RESP when resp=1).
    function automatic exp_t mk(input int port, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input bit resp);
        exp_t e;
        logic mis;
        e = blank();
        mis = (a[1:0] != 2'b00);
        e.busy = 1'b1;
        e.addr = a;
        e.sel = (a >= RAM_BASE);
        if (!resp) begin
            e.gnt0 = (port == 0);
            e.gnt1 = (port == 1);
            e.we = wr && !mis;
            e.wdata = d;
        end else begin
            e.done0 = (port == 0);
            e.done1 = (port == 1);
            e.err0 = (port == 0) && mis;
            e.err1 = (port == 1) && mis;
            if (!wr && !mis) begin
                e.rv0 = (port == 0);
                e.rv1 = (port == 1);
                e.rval = mem_fn(a);
            end
        end
        return e;
    endfunction

    function automatic int pick(input logic r0, input logic r1, input logic lk, input int last);
        if (r0 && !r1) return 0;
        if (!r0 && r1) return lk ? -1 : 1;
        if (r0 && r1) return lk ? 0 : ((last == 0) ? 1 : 0);
        return -1;
    endfunction

    always_comb p_s = pick(req0, req1, lock0, last_w);

    // Schedule model: a winner at edge k owns cycle k (grant) and cycle k+1 (done).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) slot[i] <= blank();
            next_arb <= 0;
            last_w <= 1;
        end else begin
            slot[(cyc + 2) % 64] <= blank();
            if (cyc >= next_arb && p_s >= 0) begin
                slot[cyc % 64] <= mk(p_s, (p_s == 1) ? we1 : we0, (p_s == 1) ? addr1 : addr0,
                                     (p_s == 1) ? wdata1 : wdata0, 1'b0);
                slot[(cyc + 1) % 64] <= mk(p_s, (p_s == 1) ? we1 : we0, (p_s == 1) ? addr1 : addr0,
                                           (p_s == 1) ? wdata1 : wdata0, 1'b1);
                last_w <= p_s;
                next_arb <= cyc + 2;
            end
            cyc <= cyc + 1;
        end
    end

    exp_t        ce;
    logic [31:0] hold0 = 32'h0;
    logic [31:0] hold1 = 32'h0;

    // Per-cycle comparison against the model, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                ce = blank();
                hold0 = 32'h0;
                hold1 = 32'h0;
                check("rst_mem_addr", mem_addr, 32'h0);
                check("rst_mem_wdata", mem_wdata, 32'h0);
                check("rst_mem_sel", {31'h0, mem_sel}, 32'h0);
            end else begin
                ce = slot[(cyc + 63) % 64];
            end
            check("gnt0", {31'h0, gnt0}, {31'h0, ce.gnt0});
            check("gnt1", {31'h0, gnt1}, {31'h0, ce.gnt1});
            check("done0", {31'h0, done0}, {31'h0, ce.done0});
            check("done1", {31'h0, done1}, {31'h0, ce.done1});
            check("err0", {31'h0, err0}, {31'h0, ce.err0});
            check("err1", {31'h0, err1}, {31'h0, ce.err1});
            check("mem_we", {31'h0, mem_we}, {31'h0, ce.we});
            check("busy", {31'h0, busy}, {31'h0, ce.busy});
            check("rdata0", rdata0, ce.rv0 ? ce.rval : hold0);
            check("rdata1", rdata1, ce.rv1 ? ce.rval : hold1);
            if (ce.busy) begin
                check("mem_addr", mem_addr, ce.addr);
                check("mem_sel", {31'h0, mem_sel}, {31'h0, ce.sel});
            end
            if (ce.gnt0 || ce.gnt1) check("mem_wdata", mem_wdata, ce.wdata);
            if (ce.rv0) hold0 = ce.rval;
            if (ce.rv1) hold1 = ce.rval;
        end
    end

    logic [3:0] seq;
    int         ng0, ng1;

    // Directed scenarios; inputs change on the falling edge.
    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // core read from ROM
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0040_0000; wdata0 = 32'h0;
        @(negedge clk);
        check("t1_gnt0", {31'h0, gnt0}, 32'h1);
        check("t1_sel", {31'h0, mem_sel}, 32'h0);
        check("t1_addr", mem_addr, 32'h0040_0000);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_done0", {31'h0, done0}, 32'h1);
        check("t1_rdata0", rdata0, 32'h2008_0005);
        check("t1_err0", {31'h0, err0}, 32'h0);
        @(negedge clk);
        check("t1_idle", {31'h0, busy}, 32'h0);
        // loader write to RAM
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1001_0004; wdata1 = 32'hDEAD_BEEF; lock0 = 1'b0;
        @(negedge clk);
        check("t2_gnt1", {31'h0, gnt1}, 32'h1);
        check("t2_we", {31'h0, mem_we}, 32'h1);
        check("t2_sel", {31'h0, mem_sel}, 32'h1);
        check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        req1 = 1'b0;
        @(negedge clk);
        check("t2_we_off", {31'h0, mem_we}, 32'h0);
        check("t2_done1", {31'h0, done1}, 32'h1);
        @(negedge clk);
        // both ports requesting continuously
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_0010; wdata0 = 32'h1111_2222;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0100;
        seq = 4'h0; ng0 = 0; ng1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_both", {31'h0, gnt0 & gnt1}, 32'h0);
            if (gnt0) begin seq = {seq[2:0], 1'b0}; ng0++; end
            if (gnt1) begin seq = {seq[2:0], 1'b1}; ng1++; end
        end
        check("t3_order", {28'h0, seq}, 32'h5);
        check("t3_count", ng0 + ng1, 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        // same with the core lock held, then released
        lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1;
        ng0 = 0; ng1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt0) ng0++;
            if (gnt1) ng1++;
        end
        check("t4_lock_gnt0", ng0, 32'd4);
        check("t4_lock_gnt1", ng1, 32'd0);
        lock0 = 1'b0;
        @(negedge clk);
        check("t4_unlock_gnt1", {31'h0, gnt1}, 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("t4_done1", {31'h0, done1}, 32'h1);
        check("t4_rdata1", rdata1, 32'hFFFF_FEFF);
        @(negedge clk);
        // misaligned core write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_0002; wdata0 = 32'hCAFE_F00D;
        @(negedge clk);
        check("t5_gnt0", {31'h0, gnt0}, 32'h1);
        check("t5_we", {31'h0, mem_we}, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        check("t5_done0", {31'h0, done0}, 32'h1);
        check("t5_err0", {31'h0, err0}, 32'h1);
        check("t5_rdata0", rdata0, 32'h2008_0005);
        @(negedge clk);
        check("t5_err_clr", {31'h0, err0}, 32'h0);
        // reset during the ACCESS cycle of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_0008; wdata0 = 32'h5555_AAAA;
        @(negedge clk);
        check("t6_we", {31'h0, mem_we}, 32'h1);
        reset = 1'b0;
        #1;
        check("t6_we_async", {31'h0, mem_we}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("t6_no_done", {31'h0, done0}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_regnt", {31'h0, gnt0}, 32'h1);
        check("t6_rewe", {31'h0, mem_we}, 32'h1);
        req0 = 1'b0;
        @(negedge clk);
        check("t6_done0", {31'h0, done0}, 32'h1);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read MemoryUnit port between two requesters: port 0 is the MIPS core and port 1 is the program loader/debug master.
- Arbitrates with round-robin priority and supports a core lock for atomic sequences.
- Registers the winning request, drives the memory address/data/we/mem_sel, and returns read data with a done pulse.
- Sits between the requesters and MemoryUnit; the ROM/RAM select is decoded from the address.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 32, width of byte addresses from the requesters.
- RAM_BASE, 32'h1001_0000, addresses >= RAM_BASE select RAM (mem_sel=1); lower addresses select ROM (mem_sel=0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  core request; held until gnt0 is seen.
- we0  in  1  core write (1) / read (0).
- addr0  in  ADDR_WIDTH  core byte address.
- wdata0  in  DATA_WIDTH  core write data.
- lock0  in  1  core lock; while high, port 1 is never granted.
- gnt0  out  1  one-cycle grant pulse to the core.
- done0  out  1  one-cycle completion pulse to the core.
- err0  out  1  misalignment error, valid with done0.
- rdata0  out  DATA_WIDTH  read data, valid with done0.
- req1, we1, addr1, wdata1, gnt1, done1, err1, rdata1  same as port 0, for the loader.
- mem_addr  out  ADDR_WIDTH  address to MemoryUnit.
- mem_wdata  out  DATA_WIDTH  write data to MemoryUnit.
- mem_we  out  1  memory write enable.
- mem_sel  out  1  0=ROM, 1=RAM.
- mem_q  in  DATA_WIDTH  MemoryUnit output; valid 1 cycle after the address is presented.
- busy  out  1  high in the ACCESS and RESP states.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, last_winner=1 (so the core wins the first tie).
  - All outputs 0, latched request registers 0.
- States: IDLE, ACCESS, RESP.
- Arbitration is evaluated combinationally in IDLE and in RESP, on the current req0/req1.
  - Only req0: port 0 wins.
  - Only req1 and lock0=0: port 1 wins.
  - Only req1 and lock0=1: no winner.
  - Both: the port other than last_winner wins; if lock0=1, port 0 wins.
  - No winner: RESP goes to IDLE; IDLE stays in IDLE.
- On a winner, at the clock edge:
  - Latch sel, we, addr and wdata of the winner.
  - Update last_winner.
  - Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt of the winner = 1.
  - mem_addr and mem_wdata driven from the latched request.
  - mem_sel = (addr >= RAM_BASE).
  - mem_we = latched we AND addr[1:0]==0.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - done of the winner = 1.
  - rdata of the winner = mem_q for reads (registered into rdata, held until the next done on that port). For writes rdata is unchanged.
  - err of the winner = (addr[1:0]!=0). On a misaligned access mem_we stays 0 and rdata is unchanged.
  - mem_we = 0.
  - mem_addr and mem_sel keep their latched values.
  - Arbitration runs again, allowing back-to-back grants: peak throughput is 1 access per 2 cycles.
- Latency: request sampled at edge N → gnt during cycle N+1 → done during cycle N+2.
- Requester rule: hold req and its fields stable until gnt is seen. In the cycle after gnt, either drop req or present a new request. A req still high in RESP is treated as a new request.
- Outside their states, gnt0/gnt1 and done0/done1/err0/err1 are 0. gnt and done are never high on both ports in the same cycle.
- lock0 rising while port 1 is in ACCESS or RESP does not abort that transfer; it only affects the next arbitration.
- Reset asserted mid-transfer:
  - Aborts immediately; no done is issued.
  - mem_we drops asynchronously.
- Address compare is unsigned over the full ADDR_WIDTH. Addresses are not range-checked beyond alignment.

Test Plan:
- Reset release, req0=1, we0=0, addr0=0x0040_0000, mem_q model returns 0x2008_0005 → gnt0 in cycle 2, mem_sel=0, done0 in cycle 3, rdata0=0x2008_0005, err0=0.
- req1 write addr1=0x1001_0004, wdata1=0xDEAD_BEEF, lock0=0 → mem_we=1 for exactly one cycle with mem_sel=1 and mem_wdata=0xDEAD_BEEF, then done1=1.
- req0 and req1 held high continuously for 8 cycles after reset → grants alternate 0,1,0,1; gnt pulses are 2 cycles apart; gnt never high on both ports.
- Same as previous with lock0=1 → only gnt0 pulses. lock0 dropped → the next grant goes to port 1.
- req0 write to addr0=0x1001_0002 → mem_we stays 0, done0=1 with err0=1, rdata0 unchanged.
- reset driven low during ACCESS of a write → mem_we=0 immediately, no done pulse. After release, state is IDLE and a pending req0 is granted.
